sram_responder: RTL and testbench

- Clocked, synthesizable responder for the 16-bit SRAM bus driven by the pipeline MEM stage: SRAM_DQ/ADDR/UB_N/LB_N/WB_N/CE_N/OE_N.
- Used in simulation and on-FPGA self-test as the device side of that interface.
- Stores data internally, honours byte lanes, returns read data after a programmable latency and counts transactions for the verification engineer.

---
 rtl/sram_responder.sv | 106 ++++++++++
 tb/tb_sram_responder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sram_responder.sv
// sram_responder: device side of the 16-bit SRAM bus with byte lanes, programmable read latency and transaction counters
module sram_responder #(
  parameter int ADDR_W  = 18,
  parameter int DEPTH_W = 18,
  parameter int RD_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [15:0]       SRAM_DQ,
  input  logic [ADDR_W-1:0] SRAM_ADDR,
  input  logic              SRAM_UB_N,
  input  logic              SRAM_LB_N,
  input  logic              SRAM_WB_N,
  input  logic              SRAM_CE_N,
  input  logic              SRAM_OE_N,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count,
  output logic [1:0]        state,
  output logic              wr_oe_err
);
  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DRIVE, WR} state_e;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        lanes_q, lanes_d, lanes, lane_oe;
  logic [2:0]        cnt_q, cnt_d;
  logic              drive_q, drive_d, err_q, err_d;
  logic [15:0]       rd_q, rd_d, wr_q, wr_d, rdata_q;
  logic [15:0]       mem [2**DEPTH_W];
  logic              cmd_wr, cmd_rd, accept;

  assign lanes   = {~SRAM_UB_N, ~SRAM_LB_N};
  assign cmd_wr  = ~SRAM_CE_N & ~SRAM_WB_N;
  assign cmd_rd  = ~SRAM_CE_N & SRAM_WB_N & ~SRAM_OE_N;
  assign accept  = cmd_rd & (state_q == IDLE || state_q == WR || SRAM_ADDR != addr_q || lanes != lanes_q);
  // cmd_rd doubles as the combinational release: the bus drops the moment a control deasserts
  assign lane_oe = {2{drive_q & cmd_rd}} & lanes_q;
  assign SRAM_DQ[15:8] = lane_oe[1] ? rdata_q[15:8] : 8'hzz;
  assign SRAM_DQ[7:0]  = lane_oe[0] ? rdata_q[7:0]  : 8'hzz;
  assign rd_count  = rd_q;
  assign wr_count  = wr_q;
  assign state     = state_q;
  assign wr_oe_err = err_q;

  // next-state decode: write beats read, accepted reads restart latency, anything else falls back to idle
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lanes_d = lanes_q;
    cnt_d   = cnt_q;
    drive_d = drive_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    err_d   = err_q | (cmd_wr & ~SRAM_OE_N);
    if (cmd_wr) begin
      state_d = WR;
      drive_d = 1'b0;
      cnt_d   = 3'd0;
      wr_d    = wr_q + 16'd1;
    end else if (accept) begin
      addr_d  = SRAM_ADDR;
      lanes_d = lanes;
      rd_d    = rd_q + 16'd1;
      state_d = RD_LAT == 1 ? RD_DRIVE : RD_WAIT;
      drive_d = RD_LAT == 1;
      cnt_d   = RD_LAT == 1 ? 3'd0 : 3'(RD_LAT - 1);
    end else if (cmd_rd) begin
      state_d = (state_q == RD_WAIT && cnt_q == 3'd1) ? RD_DRIVE : state_q;
      drive_d = state_d == RD_DRIVE;
      cnt_d   = cnt_q != 3'd0 ? cnt_q - 3'd1 : 3'd0;
    end else begin
      state_d = IDLE;
      drive_d = 1'b0;
      cnt_d   = 3'd0;
    end
  end

  // control and counter registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      lanes_q <= 2'b00;
      cnt_q   <= 3'd0;
      drive_q <= 1'b0;
      rd_q    <= 16'd0;
      wr_q    <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lanes_q <= lanes_d;
      cnt_q   <= cnt_d;
      drive_q <= drive_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

  // storage is unreset so it survives reset; the read register follows the latched address every edge
  always_ff @(posedge clk) begin
    if (cmd_wr & lanes[0]) mem[SRAM_ADDR[DEPTH_W-1:0]][7:0] <= SRAM_DQ[7:0];
    if (cmd_wr & lanes[1]) mem[SRAM_ADDR[DEPTH_W-1:0]][15:8] <= SRAM_DQ[15:8];
    rdata_q <= mem[addr_d[DEPTH_W-1:0]];
  end
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: scoreboard bench running identical traffic into RD_LAT=1 and RD_LAT=3 responders
module tb_sram_responder;
  typedef struct packed {logic [1:0] oe; logic [15:0] d;} exp_t;
  logic        clk = 1'b0, rst = 1'b0;
  logic [17:0] addr = '0;
  logic        ub_n = 1'b1, lb_n = 1'b1, wb_n = 1'b1, ce_n = 1'b1, oe_n = 1'b1, tb_oe = 1'b0;
  logic [15:0] tb_dq = '0;
  wire  [15:0] dq1, dq3;
  logic [15:0] rc1, wc1, rc3, wc3, p1rd, p3rd;
  logic [1:0]  st1, st3, p1, p3;
  logic        err1, err3;
  int          total = 0, bad = 0, erd = 0, ewr = 0;
  exp_t        q1[$], q3[$];

  assign dq1 = tb_oe ? tb_dq : 16'hzzzz;
  assign dq3 = tb_oe ? tb_dq : 16'hzzzz;
  always #5 clk = ~clk;

  sram_responder #(.ADDR_W(18), .DEPTH_W(16), .RD_LAT(1)) u1 (
    .clk(clk), .rst(rst), .SRAM_DQ(dq1), .SRAM_ADDR(addr), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n),
    .SRAM_WB_N(wb_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .rd_count(rc1), .wr_count(wc1),
    .state(st1), .wr_oe_err(err1));
  sram_responder #(.ADDR_W(18), .DEPTH_W(16), .RD_LAT(3)) u3 (
    .clk(clk), .rst(rst), .SRAM_DQ(dq3), .SRAM_ADDR(addr), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n),
    .SRAM_WB_N(wb_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .rd_count(rc3), .wr_count(wc3),
    .state(st3), .wr_oe_err(err3));

  function automatic logic [15:0] m(input logic [1:0] o);
    return {{8{o[1]}}, {8{o[0]}}};
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, a, e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ce_n = 1'b1; wb_n = 1'b1; oe_n = 1'b1; tb_oe = 1'b0;
  endtask

  task automatic push(input logic [1:0] o, input logic [15:0] d);
    q1.push_back({o, d});
    q3.push_back({o, d});
  endtask

  task automatic wr(input logic [17:0] a, input logic [15:0] d, input logic ub, input logic lb, input logic oe);
    addr = a; tb_dq = d; tb_oe = 1'b1; ub_n = ub; lb_n = lb; ce_n = 1'b0; wb_n = 1'b0; oe_n = oe;
    cyc();
    ewr++;
    idle();
  endtask

  task automatic rd(input logic [17:0] a, input logic ub, input logic lb, input logic [15:0] d);
    addr = a; ub_n = ub; lb_n = lb; ce_n = 1'b0; wb_n = 1'b1; oe_n = 1'b0; tb_oe = 1'b0;
    push({~ub, ~lb}, d);
    erd++;
    repeat (3) cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic counts(input string t);
    chk({t, " u1 rd_count"}, rc1, erd);
    chk({t, " u3 rd_count"}, rc3, erd);
    chk({t, " u1 wr_count"}, wc1, ewr);
    chk({t, " u3 wr_count"}, wc3, ewr);
  endtask

  // monitor: a fresh read presentation is entry into RD_DRIVE or a recount while already there
  always @(negedge clk) begin
    if (st1 == 2'd2 && (p1 != 2'd2 || rc1 != p1rd)) begin
      chk("u1 pending read", 32'(q1.size() > 0), 1);
      if (q1.size() > 0) begin
        chk("u1 lane_oe", u1.lane_oe, q1[0].oe);
        chk("u1 dq", dq1 & m(q1[0].oe), q1[0].d & m(q1[0].oe));
        q1.delete(0);
      end
    end
    if (st3 == 2'd2 && (p3 != 2'd2 || rc3 != p3rd)) begin
      chk("u3 pending read", 32'(q3.size() > 0), 1);
      if (q3.size() > 0) begin
        chk("u3 lane_oe", u3.lane_oe, q3[0].oe);
        chk("u3 dq", dq3 & m(q3[0].oe), q3[0].d & m(q3[0].oe));
        q3.delete(0);
      end
    end
    p1 <= st1; p1rd <= rc1;
    p3 <= st3; p3rd <= rc3;
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) cyc();
    chk("reset u1 state", st1, 0);
    chk("reset u3 state", st3, 0);
    chk("reset u1 lane_oe", u1.lane_oe, 0);
    chk("reset u1 err", err1, 0);
    chk("reset u3 err", err3, 0);
    counts("reset");
    wr(18'h00010, 16'hA5C3, 1'b0, 1'b0, 1'b1);
    rd(18'h00010, 1'b0, 1'b0, 16'hA5C3);
    counts("first rw");
    chk("first rw u3 state", st3, 2);
    idle(); cyc();
    wr(18'h00020, 16'h1234, 1'b0, 1'b0, 1'b1);
    wr(18'h00020, 16'hFF00, 1'b0, 1'b1, 1'b1);
    rd(18'h00020, 1'b0, 1'b0, 16'hFF34);
    rd(18'h00020, 1'b1, 1'b0, 16'h0034);
    counts("lanes");
    idle(); cyc();
    chk("nop u1 state", st1, 0);
    addr = 18'h00020; ub_n = 1'b0; lb_n = 1'b0; ce_n = 1'b0; wb_n = 1'b1; oe_n = 1'b0;
    push(2'b11, 16'hFF34);
    erd++;
    cyc();
    chk("lat3 e1 u3 state", st3, 1);
    chk("lat3 e1 u3 lane_oe", u3.lane_oe, 0);
    chk("lat3 e1 u1 state", st1, 2);
    cyc();
    chk("lat3 e2 u3 state", st3, 1);
    cyc();
    chk("lat3 e3 u3 state", st3, 2);
    chk("lat3 e3 u3 lane_oe", u3.lane_oe, 3);
    @(negedge clk); #1;
    oe_n = 1'b1;
    #1;
    chk("oe release u1", u1.lane_oe, 0);
    chk("oe release u3", u3.lane_oe, 0);
    cyc();
    chk("oe release u1 state", st1, 0);
    chk("oe release u3 state", st3, 0);
    rd(18'h00010, 1'b0, 1'b0, 16'hA5C3);
    addr = 18'h00030; tb_dq = 16'h5A5A; tb_oe = 1'b1; ub_n = 1'b0; lb_n = 1'b0; wb_n = 1'b0; oe_n = 1'b0;
    #1;
    chk("wr abort u1 lane_oe", u1.lane_oe, 0);
    chk("wr abort u3 lane_oe", u3.lane_oe, 0);
    cyc();
    ewr++;
    chk("wr_oe u1 state", st1, 3);
    chk("wr_oe u1 err", err1, 1);
    chk("wr_oe u3 err", err3, 1);
    idle();
    repeat (3) cyc();
    chk("sticky u1 err", err1, 1);
    chk("sticky u3 state", st3, 0);
    rd(18'h00030, 1'b0, 1'b0, 16'h5A5A);
    counts("wr_oe");
    idle(); cyc();
    addr = 18'h10010; ub_n = 1'b0; lb_n = 1'b0; ce_n = 1'b0; wb_n = 1'b1; oe_n = 1'b0;
    cyc();
    chk("pre reset u3 state", st3, 1);
    #2 rst = 1'b0;
    #1;
    chk("async u1 state", st1, 0);
    chk("async u3 state", st3, 0);
    chk("async u1 lane_oe", u1.lane_oe, 0);
    chk("async u3 err", err3, 0);
    erd = 0; ewr = 0;
    counts("async");
    idle();
    @(negedge clk); rst = 1'b1;
    cyc();
    rd(18'h00010, 1'b0, 1'b0, 16'hA5C3);
    rd(18'h10010, 1'b0, 1'b0, 16'hA5C3);
    counts("alias");
    idle();
    repeat (3) cyc();
    chk("u1 queue drained", q1.size(), 0);
    chk("u3 queue drained", q3.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
